// File: rtl/scurve_scan_controller.sv
// S-curve threshold scan sequencer: steps the DAC threshold, clears and runs a
// single-input S-curve counter per step, and streams a 3-word record
// (header/DAC code, pulse count, trigger count) per step to the readout FIFO.
module scurve_scan_controller #(
    parameter int unsigned DAC_WIDTH      = 10,
    parameter int unsigned CLR_CYCLES     = 4,
    parameter int unsigned SETTLE_WIDTH   = 16,
    parameter logic [31:0] TIMEOUT_CYCLES = 32'd50_000_000
) (
    input  logic                    Clk,
    input  logic                    reset_n,
    input  logic                    Scan_Start,
    input  logic                    Scan_Abort,
    input  logic [DAC_WIDTH-1:0]    DAC_Start,
    input  logic [DAC_WIDTH-1:0]    DAC_Stop,
    input  logic [DAC_WIDTH-1:0]    DAC_Step,
    input  logic [SETTLE_WIDTH-1:0] Settle_Time,
    output logic [DAC_WIDTH-1:0]    DAC_Code,
    output logic                    DAC_Load,
    input  logic                    DAC_Load_Done,
    output logic                    Cnt_Rst_n,
    output logic                    Test_Start,
    input  logic                    CPT_DONE,
    input  logic [15:0]             CPT_PULSE,
    input  logic [15:0]             CPT_TRIGGER,
    output logic [15:0]             Data_Out,
    output logic                    Data_Valid,
    input  logic                    Data_Ready,
    output logic                    Scan_Busy,
    output logic                    Scan_Done,
    output logic                    Timeout_Err
);

    typedef enum logic [3:0] {
        S_IDLE, S_LOAD, S_WAIT_DAC, S_CLEAR, S_SETTLE, S_COUNT,
        S_WR_CODE, S_WR_PULSE, S_WR_TRIG, S_NEXT, S_DONE
    } state_t;

    state_t               state, state_next;
    logic [31:0]          cyc_cnt;
    logic                 done_meta, done_sync;
    logic [DAC_WIDTH-1:0] stop_q, step_q;
    logic [15:0]          pulse_q, trig_q;
    logic                 step_timeout;
    logic [DAC_WIDTH:0]   next_code;
    logic [9:0]           hdr_code;
    logic                 scan_go, clear_last, settle_last, watchdog_hit;

    // Two-stage synchroniser for the counter's done flag (foreign clock domain).
    // NOTE: sequential state uses non-blocking assignments so every flop samples
    // pre-edge values; blocking here would collapse the two stages into one.
    always_ff @(posedge Clk or negedge reset_n) begin
        if (!reset_n) begin
            done_meta <= 1'b0;
            done_sync <= 1'b0;
        end else begin
            done_meta <= CPT_DONE;
            done_sync <= done_meta;
        end
    end

    // State register.
    always_ff @(posedge Clk or negedge reset_n) begin
        if (!reset_n) state <= S_IDLE;
        else          state <= state_next;
    end

    // Next-state logic and state-decoded outputs; abort overrides everything.
    // NOTE: every output gets a default before the case so no path leaves a
    // signal unassigned, which would otherwise infer a latch.
    always_comb begin
        state_next   = state;
        DAC_Load     = 1'b0;
        Cnt_Rst_n    = 1'b1;
        Test_Start   = 1'b0;
        Data_Valid   = 1'b0;
        Data_Out     = 16'd0;
        Scan_Busy    = (state != S_IDLE);
        Scan_Done    = 1'b0;
        next_code    = {1'b0, DAC_Code} + {1'b0, step_q};
        hdr_code     = 10'(DAC_Code);
        scan_go      = (state == S_IDLE) && Scan_Start && !Scan_Abort;
        clear_last   = (cyc_cnt == 32'(CLR_CYCLES - 1));
        settle_last  = (cyc_cnt == 32'(Settle_Time) - 32'd1);
        watchdog_hit = (cyc_cnt == TIMEOUT_CYCLES - 32'd1);

        case (state)
            S_IDLE:     if (scan_go) state_next = S_LOAD;
            S_LOAD: begin
                DAC_Load   = 1'b1;
                state_next = S_WAIT_DAC;
            end
            S_WAIT_DAC: if (DAC_Load_Done) state_next = S_CLEAR;
            S_CLEAR: begin
                Cnt_Rst_n = 1'b0;
                if (clear_last)
                    state_next = (Settle_Time == '0) ? S_COUNT : S_SETTLE;
            end
            S_SETTLE:   if (settle_last) state_next = S_COUNT;
            S_COUNT: begin
                Test_Start = 1'b1;
                if (done_sync || watchdog_hit) state_next = S_WR_CODE;
            end
            S_WR_CODE: begin
                Data_Valid = 1'b1;
                Data_Out   = {step_timeout, 5'b0, hdr_code};
                if (Data_Ready) state_next = S_WR_PULSE;
            end
            S_WR_PULSE: begin
                Data_Valid = 1'b1;
                Data_Out   = pulse_q;
                if (Data_Ready) state_next = S_WR_TRIG;
            end
            S_WR_TRIG: begin
                Data_Valid = 1'b1;
                Data_Out   = trig_q;
                if (Data_Ready) state_next = S_NEXT;
            end
            S_NEXT: begin
                // The carry bit catches wrap past the top of the DAC range.
                if (next_code[DAC_WIDTH] || (next_code > {1'b0, stop_q}))
                    state_next = S_DONE;
                else
                    state_next = S_LOAD;
            end
            S_DONE: begin
                Scan_Done  = 1'b1;
                state_next = S_IDLE;
            end
            default:    state_next = S_IDLE;
        endcase

        if (Scan_Abort) state_next = S_IDLE;
    end

    // Shared per-state cycle counter for clear, settle and the COUNT watchdog.
    always_ff @(posedge Clk or negedge reset_n) begin
        if (!reset_n)
            cyc_cnt <= '0;
        else if (state_next != state)
            cyc_cnt <= '0;
        else if (state == S_CLEAR || state == S_SETTLE || state == S_COUNT)
            cyc_cnt <= cyc_cnt + 32'd1;
    end

    // Scan configuration, current code, captured counts and timeout flags.
    always_ff @(posedge Clk or negedge reset_n) begin
        if (!reset_n) begin
            DAC_Code     <= '0;
            stop_q       <= '0;
            step_q       <= '0;
            pulse_q      <= '0;
            trig_q       <= '0;
            step_timeout <= 1'b0;
            Timeout_Err  <= 1'b0;
        end else begin
            if (scan_go) begin
                DAC_Code    <= DAC_Start;
                stop_q      <= DAC_Stop;
                step_q      <= (DAC_Step == '0) ? {{(DAC_WIDTH-1){1'b0}}, 1'b1} : DAC_Step;
                Timeout_Err <= 1'b0;
            end
            if (state == S_NEXT && state_next == S_LOAD)
                DAC_Code <= next_code[DAC_WIDTH-1:0];
            if (state_next == S_LOAD)
                step_timeout <= 1'b0;
            if (state == S_COUNT && state_next == S_WR_CODE) begin
                pulse_q <= CPT_PULSE;
                trig_q  <= CPT_TRIGGER;
                if (!done_sync) begin
                    step_timeout <= 1'b1;
                    Timeout_Err  <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_scurve_scan_controller.sv
// Directed bench for scurve_scan_controller: behavioural DAC/counter models,
// a FIFO-side word collector with optional back-pressure, and hand-built
// expected word lists per scan.
module tb_scurve_scan_controller;

    localparam int DW = 10;

    logic        Clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        Scan_Start = 1'b0, Scan_Abort = 1'b0;
    logic [DW-1:0] DAC_Start = '0, DAC_Stop = '0, DAC_Step = '0;
    logic [15:0] Settle_Time = '0;
    logic [DW-1:0] DAC_Code;
    logic        DAC_Load, DAC_Load_Done = 1'b0;
    logic        Cnt_Rst_n, Test_Start, CPT_DONE = 1'b0;
    logic [15:0] CPT_PULSE = 16'd60000, CPT_TRIGGER = 16'd30000;
    logic [15:0] Data_Out;
    logic        Data_Valid, Data_Ready = 1'b1;
    logic        Scan_Busy, Scan_Done, Timeout_Err;

    scurve_scan_controller #(
        .DAC_WIDTH(DW), .CLR_CYCLES(4), .SETTLE_WIDTH(16), .TIMEOUT_CYCLES(32'd1000)
    ) dut (
        .Clk(Clk), .reset_n(reset_n),
        .Scan_Start(Scan_Start), .Scan_Abort(Scan_Abort),
        .DAC_Start(DAC_Start), .DAC_Stop(DAC_Stop), .DAC_Step(DAC_Step),
        .Settle_Time(Settle_Time),
        .DAC_Code(DAC_Code), .DAC_Load(DAC_Load), .DAC_Load_Done(DAC_Load_Done),
        .Cnt_Rst_n(Cnt_Rst_n), .Test_Start(Test_Start),
        .CPT_DONE(CPT_DONE), .CPT_PULSE(CPT_PULSE), .CPT_TRIGGER(CPT_TRIGGER),
        .Data_Out(Data_Out), .Data_Valid(Data_Valid), .Data_Ready(Data_Ready),
        .Scan_Busy(Scan_Busy), .Scan_Done(Scan_Done), .Timeout_Err(Timeout_Err)
    );

    always #5 Clk = ~Clk;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", tag, got, got, exp, exp);
    endtask

    // Environment models, all driven on the falling edge.
    int          done_cnt = 0, load_cnt = 0;
    logic        load_prev = 1'b0;
    int          tcount = 0, last_ts_len = 0, done_delay = 200;
    logic        done_en = 1'b1;
    logic        stall_en = 1'b0, stall_bad = 1'b0;
    int          stall_cnt = 0;
    logic [15:0] stall_word = '0;
    logic [15:0] got_q[$];
    logic [15:0] exp_q[$];

    always @(negedge Clk) begin
        if (Scan_Done) done_cnt++;
        DAC_Load_Done = load_prev;
        load_prev     = DAC_Load;
        if (DAC_Load) load_cnt++;
        if (!Test_Start) begin
            if (tcount != 0) last_ts_len = tcount;
            tcount   = 0;
            CPT_DONE = 1'b0;
        end else begin
            tcount++;
            if (done_en && tcount >= done_delay) CPT_DONE = 1'b1;
        end
        if (stall_en && Data_Valid && (got_q.size() % 3) == 1 && stall_cnt < 20) begin
            if (stall_cnt == 0) stall_word = Data_Out;
            else if (Data_Out !== stall_word) stall_bad = 1'b1;
            stall_cnt++;
            Data_Ready = 1'b0;
        end else begin
            if (stall_en && stall_cnt > 0 && stall_cnt < 20) stall_bad = 1'b1;
            Data_Ready = 1'b1;
        end
        if (Data_Valid && Data_Ready) got_q.push_back(Data_Out);
    end

    task automatic start_scan(input int s, input int e, input int st, input int se);
        DAC_Start   = DW'(s);
        DAC_Stop    = DW'(e);
        DAC_Step    = DW'(st);
        Settle_Time = 16'(se);
        @(negedge Clk) Scan_Start = 1'b1;
        @(negedge Clk) Scan_Start = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int base);
        int n = 0;
        while (done_cnt == base && n < 20000) begin
            @(negedge Clk);
            n++;
        end
        repeat (5) @(negedge Clk);
        check({tag, "_scan_done_count"}, 32'(done_cnt - base), 32'd1);
    endtask

    task automatic push_rec(input logic [15:0] hdr);
        exp_q.push_back(hdr);
        exp_q.push_back(16'd60000);
        exp_q.push_back(16'd30000);
    endtask

    task automatic check_words(input string tag);
        check({tag, "_word_count"}, 32'(got_q.size()), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size(); i++)
            check($sformatf("%s_word%0d", tag, i),
                  (i < got_q.size()) ? 32'(got_q[i]) : 32'hDEAD_BEEF, 32'(exp_q[i]));
    endtask

    task automatic new_test();
        got_q.delete();
        exp_q.delete();
        load_cnt = 0;
    endtask

    initial begin
        int base;
        int n;

        // Reset state.
        repeat (3) @(negedge Clk);
        check("rst_dac_code", 32'(DAC_Code), 0);
        check("rst_strobes", {26'd0, DAC_Load, Test_Start, Data_Valid, Scan_Busy, Scan_Done, Timeout_Err}, 0);
        check("rst_cnt_rst_n", 32'(Cnt_Rst_n), 1);
        check("rst_data_out", 32'(Data_Out), 0);
        reset_n = 1'b1;
        repeat (2) @(negedge Clk);

        // Basic 3-step scan; a stray Scan_Start mid-scan must be ignored.
        new_test();
        base = done_cnt;
        start_scan(100, 104, 2, 10);
        check("t1_busy", 32'(Scan_Busy), 1);
        repeat (30) @(negedge Clk);
        Scan_Start = 1'b1;
        @(negedge Clk) Scan_Start = 1'b0;
        wait_done("t1", base);
        push_rec(16'd100); push_rec(16'd102); push_rec(16'd104);
        check_words("t1");
        check("t1_dac_loads", 32'(load_cnt), 3);
        check("t1_timeout_err", 32'(Timeout_Err), 0);
        check("t1_idle_busy", 32'(Scan_Busy), 0);

        // Same scan with 20 cycles of back-pressure on the first pulse word.
        new_test();
        stall_en = 1'b1;
        base = done_cnt;
        start_scan(100, 104, 2, 10);
        wait_done("t2", base);
        stall_en = 1'b0;
        push_rec(16'd100); push_rec(16'd102); push_rec(16'd104);
        check_words("t2");
        check("t2_stall_cycles", 32'(stall_cnt), 20);
        check("t2_stall_word", 32'(stall_word), 60000);
        check("t2_stall_stable", 32'(stall_bad), 0);

        // Top-of-range: next code 1025 exceeds 1023, so one step only.
        new_test();
        base = done_cnt;
        start_scan(1020, 1023, 5, 3);
        wait_done("t3", base);
        push_rec(16'd1020);
        check_words("t3");
        check("t3_dac_loads", 32'(load_cnt), 1);

        // Stop below start with step 0 and no settle: single step at 10.
        new_test();
        base = done_cnt;
        start_scan(10, 5, 0, 0);
        wait_done("t4", base);
        push_rec(16'd10);
        check_words("t4");
        check("t4_dac_loads", 32'(load_cnt), 1);

        // Counter never finishes: watchdog fires each step, scan continues.
        new_test();
        done_en = 1'b0;
        base = done_cnt;
        start_scan(200, 201, 1, 0);
        wait_done("t5", base);
        done_en = 1'b1;
        push_rec(16'h8000 | 16'd200); push_rec(16'h8000 | 16'd201);
        check_words("t5");
        check("t5_count_cycles", 32'(last_ts_len), 1000);
        check("t5_timeout_err", 32'(Timeout_Err), 1);

        // Abort during COUNT of step 2, then restart from DAC_Start.
        new_test();
        base = done_cnt;
        start_scan(100, 104, 2, 10);
        check("t6_timeout_cleared", 32'(Timeout_Err), 0);
        n = 0;
        while (!(load_cnt == 2 && Test_Start) && n < 5000) begin
            @(negedge Clk);
            n++;
        end
        check("t6_reached_step2_count", 32'(load_cnt == 2 && Test_Start), 1);
        Scan_Abort = 1'b1;
        @(negedge Clk) Scan_Abort = 1'b0;
        check("t6_abort_test_start", 32'(Test_Start), 0);
        check("t6_abort_busy", 32'(Scan_Busy), 0);
        check("t6_abort_valid", 32'(Data_Valid), 0);
        check("t6_abort_cnt_rst_n", 32'(Cnt_Rst_n), 1);
        repeat (300) @(negedge Clk);
        check("t6_no_scan_done", 32'(done_cnt - base), 0);
        new_test();
        start_scan(100, 104, 2, 10);
        wait_done("t6r", base);
        push_rec(16'd100); push_rec(16'd102); push_rec(16'd104);
        check_words("t6r");

        // Asynchronous reset mid-scan returns outputs to reset values at once.
        start_scan(100, 104, 2, 10);
        repeat (40) @(negedge Clk);
        #2 reset_n = 1'b0;
        #1;
        check("t7_rst_busy", 32'(Scan_Busy), 0);
        check("t7_rst_dac_code", 32'(DAC_Code), 0);
        check("t7_rst_cnt_rst_n", 32'(Cnt_Rst_n), 1);
        repeat (2) @(negedge Clk);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
